// File: rtl/div_pkg.sv
// Shared constants for the repeated-subtraction divider datapath and its controller bench.
package div_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int WIDTH_MIN     = 2;
  localparam int WIDTH_MAX     = 16;

  // Quotient reported for a divide by zero; slice the low WIDTH bits for narrower builds.
  localparam logic [WIDTH_MAX-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_sub_stage.sv
// Combinational compare/subtract step of the divider: flags rem < div and forms rem - div.
module div_sub_stage
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] div,
  output logic             lt,
  output logic [WIDTH-1:0] diff
);

  assign lt   = (rem < div);
  assign diff = rem - div;

endmodule

// File: rtl/div_dp.sv
// Repeated-subtraction divider datapath driven by an external controller (start/zero/do_iter/ready).
// Optional macro DIV_DP_CYCCNT_EN adds a 16-bit busy-cycle counter output cyc_cnt.
module div_dp
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             do_iter,
  input  logic             ready,
  output logic             zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             res_valid,
  output logic             dbz_err,
`ifdef DIV_DP_CYCCNT_EN
  output logic [15:0]      cyc_cnt,
`endif
  output logic             busy
);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] diff;
  logic             lt;
  logic             div_zero;

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .rem  (rem),
    .div  (div),
    .lt   (lt),
    .diff (diff)
  );

  assign div_zero = (div == '0);
  assign zero     = busy & (lt | div_zero);

  // Subtracting only while rem >= div keeps q bounded by the dividend, so q cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      rem       <= '0;
      div       <= '0;
      q         <= '0;
      quotient  <= '0;
      remainder <= '0;
      res_valid <= 1'b0;
      dbz_err   <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (!busy) begin
        if (start) begin
          rem  <= dividend;
          div  <= divisor;
          q    <= '0;
          busy <= 1'b1;
        end
      end else if (ready) begin
        quotient  <= div_zero ? DBZ_QUOTIENT[WIDTH-1:0] : q;
        remainder <= rem;
        dbz_err   <= div_zero;
        res_valid <= 1'b1;
        busy      <= 1'b0;
      end else if (do_iter && !zero) begin
        rem <= diff;
        q   <= q + WIDTH'(1);
      end
    end
  end

`ifdef DIV_DP_CYCCNT_EN
  // Saturates rather than wrapping for very long wide-operand divisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if (!busy && start) begin
      cyc_cnt <= '0;
    end else if (busy && (cyc_cnt != 16'hFFFF)) begin
      cyc_cnt <= cyc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div_dp.sv
// Self-checking bench for div_dp: a behavioural controller drives do_iter/ready, results checked against plain arithmetic.
module tb_div_dp;
  import div_pkg::*;

  localparam int W = 8;
  localparam int BUDGET = 400;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         do_iter;
  logic         ready;
  logic         zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         res_valid;
  logic         dbz_err;
  logic         busy;
`ifdef DIV_DP_CYCCNT_EN
  logic [15:0]  cyc_cnt;
`endif

  int checks_n = 0;
  int fails_n  = 0;

  always #5 clk = ~clk;

  div_dp #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .do_iter   (do_iter),
    .ready     (ready),
    .zero      (zero),
    .quotient  (quotient),
    .remainder (remainder),
    .res_valid (res_valid),
    .dbz_err   (dbz_err),
`ifdef DIV_DP_CYCCNT_EN
    .cyc_cnt   (cyc_cnt),
`endif
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_n++;
    assert (observed === expected)
    else begin
      fails_n++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One full division with the controller modelled cycle by cycle; optionally fires a stray start.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int inject_at);
    int exp_q, exp_r, exp_lat, edge_n, subs;
    logic exp_dbz, got, z;
    exp_dbz = (b == 0);
    exp_q   = exp_dbz ? (1 << W) - 1 : int'(a) / int'(b);
    exp_r   = exp_dbz ? int'(a) : int'(a) % int'(b);
    exp_lat = (exp_q == 0 || exp_dbz) ? 3 : exp_q + 3;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    edge_n  = 1;
    subs    = 0;
    got     = 1'b0;
    checkOutput($sformatf("busy_after_start %0d/%0d", a, b), busy, 1);
    do_iter = 1'b1;
    ready   = 1'b0;
    while (!got && edge_n < BUDGET) begin
      z = zero;
      if (do_iter && !z) subs++;
      if (edge_n == inject_at) begin
        start    = 1'b1;
        dividend = ~a;
        divisor  = 8'd3;
      end
      @(posedge clk);
      #1;
      edge_n++;
      start = 1'b0;
      if (res_valid) begin
        got = 1'b1;
      end else if (ready) begin
        ready = 1'b0;
      end else if (do_iter && z) begin
        do_iter = 1'b0;
        ready   = 1'b1;
      end
    end
    do_iter = 1'b0;
    ready   = 1'b0;
    if (!got) checkOutput($sformatf("timeout %0d/%0d", a, b), 0, 1);
    else begin
      checkOutput($sformatf("latency %0d/%0d", a, b), edge_n, exp_lat);
      checkOutput($sformatf("quotient %0d/%0d", a, b), quotient, exp_q);
      checkOutput($sformatf("remainder %0d/%0d", a, b), remainder, exp_r);
      checkOutput($sformatf("dbz_err %0d/%0d", a, b), dbz_err, exp_dbz);
      checkOutput($sformatf("subtracts %0d/%0d", a, b), subs, exp_dbz ? 0 : exp_q);
      checkOutput($sformatf("busy_done %0d/%0d", a, b), busy, 0);
`ifdef DIV_DP_CYCCNT_EN
      checkOutput($sformatf("cyc_cnt %0d/%0d", a, b), cyc_cnt, exp_lat - 1);
`endif
      @(posedge clk);
      #1;
      checkOutput($sformatf("valid_pulse %0d/%0d", a, b), res_valid, 0);
      checkOutput($sformatf("quotient_hold %0d/%0d", a, b), quotient, exp_q);
`ifdef DIV_DP_CYCCNT_EN
      checkOutput($sformatf("cyc_cnt_frozen %0d/%0d", a, b), cyc_cnt, exp_lat - 1);
`endif
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int stray;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    do_iter  = 1'b0;
    ready    = 1'b0;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_valid", res_valid, 0);
    checkOutput("reset_dbz", dbz_err, 0);
    checkOutput("reset_zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(8'd100, 8'd7, 0);
    applyStimulus(8'd5, 8'd9, 0);
    applyStimulus(8'd42, 8'd0, 0);
    applyStimulus(8'd255, 8'd1, 0);
    applyStimulus(8'd100, 8'd7, 4);

    $display("[TB] controller strobes while idle");
    @(negedge clk);
    do_iter = 1'b1;
    ready   = 1'b1;
    stray   = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) stray++;
    end
    do_iter = 1'b0;
    ready   = 1'b0;
    checkOutput("idle_no_valid", stray, 0);
    checkOutput("idle_quotient_hold", quotient, 14);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] reset in the middle of an operation");
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    do_iter = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_quotient", quotient, 0);
    checkOutput("midrst_remainder", remainder, 0);
    checkOutput("midrst_valid", res_valid, 0);
    checkOutput("midrst_zero", zero, 0);
    do_iter = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) stray++;
    end
    checkOutput("midrst_no_valid", stray, 0);
    applyStimulus(8'd9, 8'd3, 0);

    $display("[TB] random operations");
    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 20));
      applyStimulus(ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks_n, fails_n);
    $finish;
  end

endmodule

// File: doc/div_dp.md
DIV_DP -- requirements
Module: div_dp

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-004 SHALL have port start, input, 1 bit: operand load request; also drives the controller's start input.
REQ-005 SHALL have port dividend, input, WIDTH bits: captured on an accepted start.
REQ-006 SHALL have port divisor, input, WIDTH bits: captured on an accepted start.
REQ-007 SHALL have port do_iter, input, 1 bit: iteration command from the controller.
REQ-008 SHALL have port ready, input, 1 bit: operation-finished indication from the controller.
REQ-009 SHALL have port zero, output, 1 bit: termination status to the controller.
REQ-010 SHALL have port quotient, output, WIDTH bits: registered result.
REQ-011 SHALL have port remainder, output, WIDTH bits: registered result.
REQ-012 SHALL have port res_valid, output, 1 bit: one-cycle pulse when quotient/remainder update.
REQ-013 SHALL have port dbz_err, output, 1 bit: last result was a divide by zero.
REQ-014 SHALL have port busy, output, 1 bit: operation in progress.

Function
REQ-015 SHALL accept start only when busy=0; accepted start loads rem<=dividend, div<=divisor, q<=0, and sets busy=1 on that edge.
REQ-016 SHALL ignore start while busy=1; operands and working registers stay unchanged.
REQ-017 SHALL drive zero combinationally: zero = busy & ((rem < div) | (div == 0)).
REQ-018 SHALL, on do_iter=1 and zero=0, update rem<=rem-div and q<=q+1 in the same edge.
REQ-019 SHALL hold working registers when do_iter=1 and zero=1; this guards the controller's final iterate cycle.
REQ-020 SHALL, on ready=1 with busy=1: copy q to quotient and rem to remainder, set dbz_err=(div==0), pulse res_valid for exactly one cycle, and clear busy.
REQ-021 SHALL, on divide by zero, load quotient with all ones and remainder with the dividend.
REQ-022 SHALL have a latency from start to res_valid of q+3 cycles when q>0, and 3 cycles when q=0. The cycles are: initial, q subtracts, one zero-detect iterate, final, then registered output.
REQ-023 SHALL ignore do_iter and ready while busy=0.
REQ-024 SHALL hold quotient, remainder and dbz_err between operations.
REQ-025 SHALL never let q wrap: q never exceeds 2^WIDTH-1, and dividend=max with divisor=1 ends at exactly max.

Reset
REQ-026 SHALL, on rst_n=0 and asynchronously, clear busy, rem, div, q, quotient, remainder, res_valid and dbz_err to 0, so zero=0.
REQ-027 SHALL, on reset mid-operation, abandon the operation; no res_valid follows until a new accepted start.

Configuration
REQ-028 SHALL provide macro DIV_DP_CYCCNT_EN. When defined, it adds output cyc_cnt (16 bits). cyc_cnt counts busy cycles of the current operation, is frozen at res_valid, is cleared on accepted start, and resets to 0.
REQ-029 SHALL, without DIV_DP_CYCCNT_EN, omit the cyc_cnt port and counter; all other behaviour is identical.

Structure
REQ-030 SHALL place the WIDTH default, the WIDTH range limits, and the all-ones divide-by-zero quotient constant in a shared package div_pkg, which the controller bench also uses.
REQ-031 SHALL implement the compare/subtract path as sub-module div_sub_stage: inputs rem, div; outputs lt, diff; purely combinational.
REQ-032 SHALL keep all registers in div_dp itself; div_dp pairs with the existing controller (start, zero, do_iter, ready) without glue logic.

Verification (WIDTH=8, paired with the controller)
REQ-033 SHALL cover: dividend=100, divisor=7 -> 14 do_iter subtracts; quotient=14, remainder=2, dbz_err=0; res_valid 17 cycles after start.
REQ-034 SHALL cover: dividend=5, divisor=9 -> zero=1 in the initial cycle; no iterate; quotient=0, remainder=5; res_valid 3 cycles after start.
REQ-035 SHALL cover: dividend=42, divisor=0 -> zero=1 immediately; quotient=255, remainder=42, dbz_err=1.
REQ-036 SHALL cover: dividend=255, divisor=1 -> quotient=255, remainder=0, with no q wrap and rem never underflowing.
REQ-037 SHALL cover: second start pulse 4 cycles into a 100/7 operation with different operands -> ignored; result is still 14 r 2.
REQ-038 SHALL cover: rst_n low for 1 cycle mid-iteration of 100/7 -> all outputs 0, busy=0, no res_valid; next 9/3 -> quotient=3, remainder=0.
